mul_add_seq: RTL and testbench

- Sequential radix-2 shift-add unit computing result = a*b + c. This is the inverse of the pipelined divider: it rebuilds a dividend from a quotient, divisor and remainder.
- Used for divide-result checking and for fixed-point rescaling where a full-width combinational multiplier is too costly.
- Processes one multiplier bit per cycle; one operation in flight; valid/busy handshake.

---
 rtl/mul_add_seq.sv | 120 ++++++++++++
 tb/tb_mul_add_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_add_seq.sv
// mul_add_seq: sequential radix-2 shift-add unit, result = a*b + c (unsigned).
// Define EARLY_TERM_EN to end RUN as soon as the remaining multiplier bits are zero.
module mul_add_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] c_in,
    input  logic             data_valid_in,
    output logic [WIDTH-1:0] result_out,
    output logic             data_valid_out,
    output logic             error_out,
    output logic             busy_out
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = 2 * WIDTH + 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mreg_q, mreg_d;
    logic [2*WIDTH-1:0] breg_q, breg_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               err_q, err_d;
    logic               dv_q, dv_d;
    logic               accept;
    logic               last;

    assign accept = data_valid_in && (state_q != RUN);

`ifdef EARLY_TERM_EN
    // Stop once this step consumes the last set multiplier bit.
    assign last = (cnt_q == CW'(WIDTH - 1)) || (mreg_q[WIDTH-1:1] == '0);
`else
    assign last = (cnt_q == CW'(WIDTH - 1));
`endif

    always_comb begin
        state_d = state_q;
        mreg_d  = mreg_q;
        breg_d  = breg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err_d   = err_q;
        dv_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            RUN: begin
                if (mreg_q[0]) begin
                    acc_d = acc_q + AW'(breg_q);
                end
                mreg_d = mreg_q >> 1;
                breg_d = breg_q << 1;
                cnt_d  = cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                res_d   = acc_q[WIDTH-1:0];
                err_d   = |acc_q[AW-1:WIDTH];
                dv_d    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Loading in DONE still publishes the finished result above.
        if (accept) begin
            mreg_d  = a_in;
            breg_d  = {{WIDTH{1'b0}}, b_in};
            acc_d   = {{(WIDTH + 1){1'b0}}, c_in};
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            mreg_q  <= '0;
            breg_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mreg_q  <= mreg_d;
            breg_q  <= breg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
            dv_q    <= dv_d;
        end
    end

    assign result_out     = res_q;
    assign error_out      = err_q;
    assign data_valid_out = dv_q;
    assign busy_out       = (state_q == RUN);

endmodule

// File: tb/tb_mul_add_seq.sv
// Testbench for mul_add_seq at WIDTH=8: vector table, random ops vs an
// arithmetic model, and handshake/reset corner sequences.
module tb_mul_add_seq;

    localparam int W = 8;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [W-1:0] c_in = '0;
    logic         data_valid_in = 1'b0;
    logic [W-1:0] result_out;
    logic         data_valid_out;
    logic         error_out;
    logic         busy_out;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [W-1:0] res;
        logic         err;
    } vec_t;

    vec_t tbl[12];

    mul_add_seq #(.WIDTH(W)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .a_in           (a_in),
        .b_in           (b_in),
        .c_in           (c_in),
        .data_valid_in  (data_valid_in),
        .result_out     (result_out),
        .data_valid_out (data_valid_out),
        .error_out      (error_out),
        .busy_out       (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Number of RUN cycles the spec promises for multiplier a.
    function automatic int model_lat(input logic [W-1:0] a);
`ifdef EARLY_TERM_EN
        int m = 0;
        for (int i = 0; i < W; i++) if (a[i]) m = i;
        return m + 1;
`else
        return W;
`endif
    endfunction

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c);
        @(negedge clk_in);
        a_in = a;
        b_in = b;
        c_in = c;
        data_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        data_valid_in = 1'b0;
    endtask

    // Called #1 after the accept edge; counts edges up to the pulse.
    task automatic collect(output int edges, output int busyc,
                           output logic [W-1:0] res, output logic err);
        edges = 0;
        busyc = busy_out ? 1 : 0;
        res   = '0;
        err   = 1'b0;
        for (int i = 1; i <= 4 * W; i++) begin
            @(posedge clk_in);
            #1;
            if (data_valid_out) begin
                edges = i;
                res   = result_out;
                err   = error_out;
                break;
            end
            if (busy_out) busyc++;
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] c,
                          input logic [W-1:0] eres, input logic eerr);
        int edges, busyc;
        logic [W-1:0] res;
        logic err;
        int lat;
        lat = model_lat(a);
        start(a, b, c);
        collect(edges, busyc, res, err);
        check({name, ".lat"}, edges, lat + 1);
        check({name, ".busy"}, busyc, lat);
        check({name, ".res"}, res, eres);
        check({name, ".err"}, err, eerr);
    endtask

    task automatic count_pulses(input int cycles, output int pulses,
                                output logic [W-1:0] first_res);
        pulses = 0;
        first_res = '0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk_in);
            #1;
            if (data_valid_out) begin
                if (pulses == 0) first_res = result_out;
                pulses++;
            end
        end
    endtask

    initial begin
        int pulses, edges, busyc;
        logic [W-1:0] r;
        logic e;
        logic [63:0] full;
        logic [W-1:0] ra, rb, rc;

        tbl[0]  = '{8'd13,  8'd7,   8'd5,   8'd96,  1'b0};
        tbl[1]  = '{8'd255, 8'd255, 8'd0,   8'd1,   1'b1};
        tbl[2]  = '{8'd255, 8'd1,   8'd1,   8'd0,   1'b1};
        tbl[3]  = '{8'd0,   8'd200, 8'd77,  8'd77,  1'b0};
        tbl[4]  = '{8'd200, 8'd0,   8'd9,   8'd9,   1'b0};
        tbl[5]  = '{8'd3,   8'd10,  8'd0,   8'd30,  1'b0};
        tbl[6]  = '{8'd0,   8'd0,   8'd9,   8'd9,   1'b0};
        tbl[7]  = '{8'd255, 8'd255, 8'd255, 8'd0,   1'b1};
        tbl[8]  = '{8'd1,   8'd255, 8'd0,   8'd255, 1'b0};
        tbl[9]  = '{8'd16,  8'd16,  8'd0,   8'd0,   1'b1};
        tbl[10] = '{8'd15,  8'd17,  8'd0,   8'd255, 1'b0};
        tbl[11] = '{8'd128, 8'd2,   8'd3,   8'd3,   1'b1};

        // Reset state
        #12;
        check("rst.res", result_out, 0);
        check("rst.dv", data_valid_out, 0);
        check("rst.err", error_out, 0);
        check("rst.busy", busy_out, 0);
        @(negedge clk_in);
        rst_in = 1'b1;

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].c,
                   tbl[i].res, tbl[i].err);

        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = W'($urandom);
            if (i % 5 == 0) ra = W'($urandom_range(0, 3));
            full = 64'(ra) * 64'(rb) + 64'(rc);
            run_op($sformatf("rnd%0d", i), ra, rb, rc,
                   full[W-1:0], (full >> W) != 0);
        end

        // Strobe during RUN must be ignored
        start(8'd13, 8'd7, 8'd5);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        a_in = 8'd2;
        b_in = 8'd2;
        c_in = 8'd0;
        data_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        data_valid_in = 1'b0;
        count_pulses(4 * W, pulses, r);
        check("ign.pulses", pulses, 1);
        check("ign.res", r, 96);

        // Back-to-back accept in DONE
        start(8'd255, 8'd255, 8'd0);
        edges = 0;
        for (int i = 1; i <= 4 * W; i++) begin
            @(posedge clk_in);
            #1;
            if (!busy_out) begin
                edges = i;
                break;
            end
        end
        check("b2b.done_at", edges, model_lat(8'd255));
        a_in = 8'd3;
        b_in = 8'd4;
        c_in = 8'd1;
        data_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        data_valid_in = 1'b0;
        check("b2b.dv1", data_valid_out, 1);
        check("b2b.res1", result_out, 1);
        check("b2b.err1", error_out, 1);
        check("b2b.busy", busy_out, 1);
        collect(edges, busyc, r, e);
        check("b2b.lat2", edges, model_lat(8'd3) + 1);
        check("b2b.res2", r, 13);
        check("b2b.err2", e, 0);

        // Async reset mid-RUN
        start(8'd200, 8'd100, 8'd50);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        check("mrst.res", result_out, 0);
        check("mrst.dv", data_valid_out, 0);
        check("mrst.err", error_out, 0);
        check("mrst.busy", busy_out, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        count_pulses(3 * W, pulses, r);
        check("mrst.pulses", pulses, 0);
        run_op("mrst.after", 8'd5, 8'd6, 8'd7, 8'd37, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
